sprite_renderer_multi: RTL and testbench
========================================

// Module: sprite_renderer_multi
// PURPOSE
// Parametrised VGA scan-out engine: generates 640x480 timing and composites NUM_SPRITES
// square sprites over a flat background colour. Each sprite has its own position, image
// index and enable. All sprites share one external sprite ROM with a fixed 1-cycle read
// latency. Sync and colour are pipeline-aligned. Positions update only at frame
// boundaries, so there is no tearing. Sits between the game-logic block and the VGA pins.
// PARAMETERS
// NUM_SPRITES    5    number of sprite slots, 1..8; slot 0 has highest priority
// TILE_LOG2      5    log2 of the sprite edge in pixels (5 gives 32x32)
// IMG_W          2    width of the per-sprite image index (2**IMG_W images in the ROM)
// H_VISIBLE_AREA 640  H_FRONT_PORCH 16  H_SYNC_PULSE 96  H_TOTAL 800
// V_VISIBLE_AREA 480  V_FRONT_PORCH 10  V_SYNC_PULSE 2   V_TOTAL 525
// BG_COLOR       9'h000  background RGB333 value
// TRANSP_KEY     9'h1C7  ROM value treated as transparent (magenta)
// PORTS
// i_Clk          in   1                 pixel clock (25.175 MHz)
// i_Rst_L        in   1                 reset, synchronous, active-low
// i_Sprite_X     in   NUM_SPRITES*10    X of the top-left corner; slot k is bits [10k+9:10k]
// i_Sprite_Y     in   NUM_SPRITES*9     Y of the top-left corner; slot k is bits [9k+8:9k]
// i_Sprite_Img   in   NUM_SPRITES*IMG_W image index per slot
// i_Sprite_En    in   NUM_SPRITES       per-slot enable
// o_Rom_Addr     out  IMG_W+2*TILE_LOG2 ROM address = {img,row,col}
// o_Rom_Rd_En    out  1                 ROM read strobe
// i_Rom_Data     in   9                 RGB333; valid exactly 1 cycle after o_Rom_Rd_En
// o_Frame_Start  out  1                 1-cycle pulse when the sprite registers load
// o_VGA_HSync    out  1                 active-low
// o_VGA_VSync    out  1                 active-low
// o_VGA_Red      out  3                 red component
// o_VGA_Grn      out  3                 green component
// o_VGA_Blu      out  3                 blue component
// BEHAVIOUR
// - Reset (i_Rst_L=0 at a clock edge): h_cnt=0, v_cnt=0.
//   Pipeline regs: HSync=1, VSync=1, colour=0.
//   o_Rom_Rd_En=0, o_Rom_Addr=0, o_Frame_Start=0.
//   Shadow registers: all enables=0, X=Y=Img=0. Reset mid-line aborts the frame; no partial state survives.
// - Counters: h_cnt wraps at H_TOTAL-1; v_cnt increments on the h wrap and wraps at V_TOTAL-1.
// - Shadow load: on the cycle with h_cnt==0 and v_cnt==V_VISIBLE_AREA, all i_Sprite_* inputs are
//   captured into shadow regs, and o_Frame_Start=1 on the following cycle only. Input changes at
//   any other time have no effect on the image.
// - Pipeline for counter value (h,v) at cycle t:
//   S1 (t+1): hit test and priority select.
//     hit_k = en_k && h>=X_k && h<X_k+2**TILE_LOG2 && v>=Y_k && v<Y_k+2**TILE_LOG2.
//     Compare in 11-bit unsigned arithmetic, so a sprite straddling the right or bottom edge
//     clips and never wraps to x=0 or y=0.
//     The lowest-index hit wins. o_Rom_Addr={Img_k, (v-Y_k)[TILE_LOG2-1:0], (h-X_k)[TILE_LOG2-1:0]}.
//     o_Rom_Rd_En=hit_any && visible.
//   S2 (t+2): i_Rom_Data is valid; hit flag is delayed alongside it.
//   S3 (t+3): colour register gets BG_COLOR if !hit or i_Rom_Data==TRANSP_KEY, else i_Rom_Data.
//     Outside the visible area the colour register is 0.
// - Sync: HSync=0 iff H_VISIBLE_AREA+H_FRONT_PORCH <= h < that+H_SYNC_PULSE (V likewise).
//   The sync decode is delayed 3 cycles, identical to colour, so the sync and colour for pixel
//   (h,v) leave together at t+3.
// - A transparent pixel of the winning sprite shows the background, not a lower-priority
//   sprite (single ROM port).
// - When o_Rom_Rd_En=0, o_Rom_Addr holds its previous value.
// - Sprites with Y>=V_VISIBLE_AREA or X>=H_VISIBLE_AREA are never drawn.
//   X,Y=0 draws starting at pixel (0,0).
// TESTING
// - Reset, then release: the first active HSync low begins at cycle 656+3 after release.
//   HSync stays low for 96 cycles. VSync is low on lines 490-491. Frame period is 420000 cycles.
// - Slot 0 enabled at (100,50) with img 1. Fed at S2 from a model ROM where data=addr[8:0].
//   Pixel (100,50) -> o_Rom_Addr=0x400, colour at t+3 equals ROM word 0x400[8:0].
//   Pixel (131,81) -> o_Rom_Addr=0x7FF. Pixel (132,50) -> BG_COLOR.
// - Slots 0 and 3 overlap at (200,200): the slot-0 image is shown.
//   Disable slot 0 at the next shadow load -> slot 3 is shown from the next frame.
// - ROM returns 9'h1C7 inside the sprite -> output is BG_COLOR.
// - Sprite at X=620: columns 620-639 are drawn, and pixel 0 of the next line is background (no wrap).
//   Sprite at Y=470: rows 470-479 only.
// - Change i_Sprite_X mid-frame -> the image is unchanged until o_Frame_Start.
//   Assert i_Rst_L=0 mid-line -> all outputs take their reset values on the next edge.

Source files
------------

// File: rtl/sprite_renderer_multi.sv
// VGA scan-out with NUM_SPRITES prioritised square sprites over a flat background.
// Three-stage pipeline: hit/ROM address, ROM data return, colour/sync output.
module sprite_renderer_multi #(
  parameter int          NUM_SPRITES    = 5,
  parameter int          TILE_LOG2      = 5,
  parameter int          IMG_W          = 2,
  parameter int          H_VISIBLE_AREA = 640,
  parameter int          H_FRONT_PORCH  = 16,
  parameter int          H_SYNC_PULSE   = 96,
  parameter int          H_TOTAL        = 800,
  parameter int          V_VISIBLE_AREA = 480,
  parameter int          V_FRONT_PORCH  = 10,
  parameter int          V_SYNC_PULSE   = 2,
  parameter int          V_TOTAL        = 525,
  parameter logic [8:0]  BG_COLOR       = 9'h000,
  parameter logic [8:0]  TRANSP_KEY     = 9'h1C7
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst_L,
  input  logic [NUM_SPRITES*10-1:0]        i_Sprite_X,
  input  logic [NUM_SPRITES*9-1:0]         i_Sprite_Y,
  input  logic [NUM_SPRITES*IMG_W-1:0]     i_Sprite_Img,
  input  logic [NUM_SPRITES-1:0]           i_Sprite_En,
  output logic [IMG_W+2*TILE_LOG2-1:0]     o_Rom_Addr,
  output logic                             o_Rom_Rd_En,
  input  logic [8:0]                       i_Rom_Data,
  output logic                             o_Frame_Start,
  output logic                             o_VGA_HSync,
  output logic                             o_VGA_VSync,
  output logic [2:0]                       o_VGA_Red,
  output logic [2:0]                       o_VGA_Grn,
  output logic [2:0]                       o_VGA_Blu
);

  localparam int          AW   = IMG_W + 2*TILE_LOG2;
  localparam logic [10:0] TILE = 11'(1 << TILE_LOG2);

  logic [9:0]             r_h_cnt, r_v_cnt;
  logic [9:0]             r_sh_x   [NUM_SPRITES];
  logic [8:0]             r_sh_y   [NUM_SPRITES];
  logic [IMG_W-1:0]       r_sh_img [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] r_sh_en;

  logic                   r_hit1, r_hit2, r_vis1, r_vis2;
  logic [1:0]             r_hs_d, r_vs_d;
  logic [8:0]             r_color;

  logic                   w_load, w_vis, w_hs, w_vs, w_hit_any;
  logic [AW-1:0]          w_addr;

  assign w_load = (r_h_cnt == '0) && (r_v_cnt == 10'(V_VISIBLE_AREA));
  assign w_vis  = (r_h_cnt < 10'(H_VISIBLE_AREA)) && (r_v_cnt < 10'(V_VISIBLE_AREA));
  assign w_hs   = !((r_h_cnt >= 10'(H_VISIBLE_AREA + H_FRONT_PORCH)) &&
                    (r_h_cnt <  10'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE)));
  assign w_vs   = !((r_v_cnt >= 10'(V_VISIBLE_AREA + V_FRONT_PORCH)) &&
                    (r_v_cnt <  10'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE)));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == 10'(H_TOTAL - 1)) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == 10'(V_TOTAL - 1)) ? '0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // 11-bit compares so a sprite near the right/bottom edge clips instead of wrapping;
  // tile-local offsets only need the low TILE_LOG2 bits of the modular difference.
  always_comb begin
    logic hit;
    w_hit_any = 1'b0;
    w_addr    = '0;
    for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
      hit = r_sh_en[k] &&
            ({1'b0, r_h_cnt} >= {1'b0, r_sh_x[k]}) &&
            ({1'b0, r_h_cnt} <  ({1'b0, r_sh_x[k]} + TILE)) &&
            ({1'b0, r_v_cnt} >= {2'b0, r_sh_y[k]}) &&
            ({1'b0, r_v_cnt} <  ({2'b0, r_sh_y[k]} + TILE));
      if (hit && !w_hit_any) begin
        w_hit_any = 1'b1;
        w_addr    = {r_sh_img[k],
                     r_v_cnt[TILE_LOG2-1:0] - r_sh_y[k][TILE_LOG2-1:0],
                     r_h_cnt[TILE_LOG2-1:0] - r_sh_x[k][TILE_LOG2-1:0]};
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
        r_sh_x[k]   <= '0;
        r_sh_y[k]   <= '0;
        r_sh_img[k] <= '0;
      end
      r_sh_en       <= '0;
      o_Frame_Start <= 1'b0;
      o_Rom_Rd_En   <= 1'b0;
      o_Rom_Addr    <= '0;
      r_hit1        <= 1'b0;
      r_hit2        <= 1'b0;
      r_vis1        <= 1'b0;
      r_vis2        <= 1'b0;
      r_hs_d        <= '1;
      r_vs_d        <= '1;
      o_VGA_HSync   <= 1'b1;
      o_VGA_VSync   <= 1'b1;
      r_color       <= '0;
    end else begin
      o_Frame_Start <= w_load;
      if (w_load) begin
        for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
          r_sh_x[k]   <= i_Sprite_X[10*k +: 10];
          r_sh_y[k]   <= i_Sprite_Y[9*k +: 9];
          r_sh_img[k] <= i_Sprite_Img[IMG_W*k +: IMG_W];
        end
        r_sh_en <= i_Sprite_En;
      end

      o_Rom_Rd_En <= w_hit_any && w_vis;
      if (w_hit_any && w_vis)
        o_Rom_Addr <= w_addr;

      r_hit1 <= w_hit_any;
      r_vis1 <= w_vis;
      r_hit2 <= r_hit1;
      r_vis2 <= r_vis1;

      r_hs_d      <= {r_hs_d[0], w_hs};
      r_vs_d      <= {r_vs_d[0], w_vs};
      o_VGA_HSync <= r_hs_d[1];
      o_VGA_VSync <= r_vs_d[1];

      if (!r_vis2)
        r_color <= '0;
      else if (!r_hit2 || (i_Rom_Data == TRANSP_KEY))
        r_color <= BG_COLOR;
      else
        r_color <= i_Rom_Data;
    end
  end

  assign o_VGA_Red = r_color[8:6];
  assign o_VGA_Grn = r_color[5:3];
  assign o_VGA_Blu = r_color[2:0];

endmodule

// File: tb/tb_sprite_renderer_multi.sv
// Randomised bench for sprite_renderer_multi on a shrunken raster (160x72 total, 128x64 visible),
// checked every cycle against a per-pixel reference model plus hand-computed literal pixels.
module tb_sprite_renderer_multi;

  localparam int NS = 5, IMGW = 2, TL = 5, TILE = 32, AW = IMGW + 2*TL;
  localparam int HV = 128, HF = 8, HSP = 16, HT = 160;
  localparam int VV = 64,  VF = 3, VSP = 2,  VT = 72;
  localparam int FRAME = HT*VT;
  localparam logic [8:0] BG = 9'h0A5, KEY = 9'h1C7;

  logic                 clk = 1'b0, rst_n = 1'b0;
  logic [NS*10-1:0]     sp_x = '0;
  logic [NS*9-1:0]      sp_y = '0;
  logic [NS*IMGW-1:0]   sp_img = '0;
  logic [NS-1:0]        sp_en = '0;
  logic [AW-1:0]        rom_addr;
  logic                 rom_rd;
  logic [8:0]           rom_q = '0;
  logic                 fs, hs, vs;
  logic [2:0]           red, grn, blu;

  sprite_renderer_multi #(
    .NUM_SPRITES(NS), .TILE_LOG2(TL), .IMG_W(IMGW),
    .H_VISIBLE_AREA(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HSP), .H_TOTAL(HT),
    .V_VISIBLE_AREA(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VSP), .V_TOTAL(VT),
    .BG_COLOR(BG), .TRANSP_KEY(KEY)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Sprite_X(sp_x), .i_Sprite_Y(sp_y), .i_Sprite_Img(sp_img), .i_Sprite_En(sp_en),
    .o_Rom_Addr(rom_addr), .o_Rom_Rd_En(rom_rd), .i_Rom_Data(rom_q),
    .o_Frame_Start(fs), .o_VGA_HSync(hs), .o_VGA_VSync(vs),
    .o_VGA_Red(red), .o_VGA_Grn(grn), .o_VGA_Blu(blu)
  );

  always #5 clk = ~clk;

  // External ROM: word = addr[8:0], one cycle latency; garbage when not read.
  always @(posedge clk) rom_q <= rom_rd ? 9'(rom_addr) : 9'($urandom);

  int n_checks = 0, n_fail = 0;
  int n = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  // Reference model: frame state derived from the cycle count since reset.
  int sx[NS], sy[NS], simg[NS];
  bit sen[NS];
  int exp_rd = 0, exp_addr = 0, exp_fs = 0;
  int pcol[3], phs[3], pvs[3];

  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0; exp_rd = 0; exp_addr = 0; exp_fs = 0;
      for (int i = 0; i < 3; i++) begin pcol[i] = 0; phs[i] = 1; pvs[i] = 1; end
      for (int k = 0; k < NS; k++) begin sx[k] = 0; sy[k] = 0; simg[k] = 0; sen[k] = 0; end
    end else begin
      int h, v, win, a, c;
      bit vis;
      h = n % HT;
      v = (n / HT) % VT;
      vis = (h < HV) && (v < VV);
      win = -1;
      a = 0;
      for (int k = 0; k < NS; k++)
        if (win < 0 && sen[k] && h >= sx[k] && h < sx[k] + TILE && v >= sy[k] && v < sy[k] + TILE)
          win = k;
      if (win >= 0) a = simg[win]*1024 + (v - sy[win])*32 + (h - sx[win]);
      exp_rd = (win >= 0 && vis) ? 1 : 0;
      if (exp_rd == 1) exp_addr = a;
      if (!vis) c = 0;
      else if (win < 0 || (a % 512) == KEY) c = BG;
      else c = a % 512;
      pcol[2] = pcol[1]; pcol[1] = pcol[0]; pcol[0] = c;
      phs[2] = phs[1]; phs[1] = phs[0]; phs[0] = (h >= HV+HF && h < HV+HF+HSP) ? 0 : 1;
      pvs[2] = pvs[1]; pvs[1] = pvs[0]; pvs[0] = (v >= VV+VF && v < VV+VF+VSP) ? 0 : 1;
      exp_fs = (h == 0 && v == VV) ? 1 : 0;
      if (exp_fs == 1)
        for (int k = 0; k < NS; k++) begin
          sx[k]   = int'(sp_x[10*k +: 10]);
          sy[k]   = int'(sp_y[9*k +: 9]);
          simg[k] = int'(sp_img[IMGW*k +: IMGW]);
          sen[k]  = sp_en[k];
        end
      n++;
    end
  end

  function automatic int px(input int f, input int x, input int y);
    return f*FRAME + y*HT + x;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("rd_en",       rom_rd,   exp_rd);
      check("rom_addr",    rom_addr, exp_addr);
      check("frame_start", fs,       exp_fs);
      check("hsync",       hs,       phs[2]);
      check("vsync",       vs,       pvs[2]);
      check("colour",      {red, grn, blu}, pcol[2]);
      if (rst_n) begin
        if (n == 138) check("lit_hsync_pre",  hs, 1);
        if (n == 139) check("lit_hsync_low",  hs, 0);
        if (n == 154) check("lit_hsync_last", hs, 0);
        if (n == 155) check("lit_hsync_end",  hs, 1);
        if (n == 10241) check("lit_fs_pulse", fs, 1);
        if (n == 10242) check("lit_fs_drop",  fs, 0);
        if (n == 10722) check("lit_vsync_pre",  vs, 1);
        if (n == 10723) check("lit_vsync_low",  vs, 0);
        if (n == 11042) check("lit_vsync_last", vs, 0);
        if (n == 11043) check("lit_vsync_end",  vs, 1);
        if (n == px(1, 40, 20) + 1) begin
          check("lit_rd_40_20", rom_rd, 1);
          check("lit_addr_40_20", rom_addr, 'h400);
        end
        if (n == px(1, 40, 20) + 3)  check("lit_col_40_20",  {red, grn, blu}, 'h000);
        if (n == px(1, 71, 51) + 1)  check("lit_addr_71_51", rom_addr, 'h7FF);
        if (n == px(1, 71, 51) + 3)  check("lit_col_71_51",  {red, grn, blu}, 'h1FF);
        if (n == px(1, 72, 20) + 3)  check("lit_col_72_20",  {red, grn, blu}, BG);
        if (n == px(1, 47, 34) + 3)  check("lit_transp",     {red, grn, blu}, BG);
        if (n == px(1, 60, 40) + 1)  check("lit_addr_ovl",   rom_addr, 'h694);
        if (n == px(1, 60, 40) + 3)  check("lit_col_ovl",    {red, grn, blu}, 'h094);
        if (n == px(1, 127, 5) + 1)  check("lit_addr_redge", rom_addr, 'hC07);
        if (n == px(1, 127, 5) + 3)  check("lit_col_redge",  {red, grn, blu}, 'h007);
        if (n == px(1, 130, 5) + 3)  check("lit_col_blank",  {red, grn, blu}, 0);
        if (n == px(1, 0, 6) + 3)    check("lit_col_nowrap", {red, grn, blu}, BG);
        if (n == px(1, 10, 63) + 3)  check("lit_col_bedge",  {red, grn, blu}, 'h060);
        if (n == px(2, 40, 20) + 3)  check("lit_col_dis0",   {red, grn, blu}, BG);
        if (n == px(2, 47, 34) + 3)  check("lit_col_slot3a", {red, grn, blu}, 'h082);
        if (n == px(2, 60, 40) + 3)  check("lit_col_slot3b", {red, grn, blu}, 'h14F);
      end
    end
  end

  int cx[NS], cy[NS], ci[NS];
  bit ce[NS];

  task automatic apply_cfg();
    for (int k = 0; k < NS; k++) begin
      sp_x[10*k +: 10]      = 10'(cx[k]);
      sp_y[9*k +: 9]        = 9'(cy[k]);
      sp_img[IMGW*k +: IMGW] = IMGW'(ci[k]);
      sp_en[k]              = ce[k];
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_hsync"},  hs, 1);
    check({tag, "_vsync"},  vs, 1);
    check({tag, "_colour"}, {red, grn, blu}, 0);
    check({tag, "_rd_en"},  rom_rd, 0);
    check({tag, "_addr"},   rom_addr, 0);
    check({tag, "_fs"},     fs, 0);
  endtask

  initial begin
    bit c_done;
    c_done = 1'b0;
    cx = '{40, 120, 10, 45, 200};
    cy = '{20, 5, 60, 30, 0};
    ci = '{1, 3, 0, 2, 1};
    ce = '{1, 1, 1, 1, 1};
    apply_cfg();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    reset_checks("reset");
    rst_n = 1'b1;

    while (n < 3*FRAME + 40*HT + 50) begin
      @(negedge clk);
      if ((n >= 10300 && n < 21000) || (n >= 23100 && n < 32500)) begin
        sp_x = {$urandom, $urandom};
        sp_y = {$urandom, $urandom};
        sp_img = NS*IMGW'($urandom);
        sp_en = NS'($urandom);
      end else if (n >= 21000 && n < 23100) begin
        ce[0] = 1'b0;
        apply_cfg();
      end else if (n >= 32500 && !c_done) begin
        for (int k = 0; k < NS; k++) begin
          cx[k] = $urandom_range(0, 150);
          cy[k] = $urandom_range(0, 80);
          ci[k] = $urandom_range(0, 3);
          ce[k] = ($urandom_range(0, 3) != 0);
        end
        cx[1] = 0; cy[1] = 0; ce[1] = 1'b1;
        apply_cfg();
        c_done = 1'b1;
      end
    end

    rst_n = 1'b0;
    @(negedge clk);
    reset_checks("midline_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
